// File: rtl/signal_condenser.sv
// signal_condenser: debounces one async level into level, pulse and events.
// Build option: define SIGNAL_CONDENSER_FALL_EN to enable fall_pulse.
module signal_condenser #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in,
  output logic       level,
  output logic       pulse,
  output logic       fall_pulse,
  output logic [7:0] events
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam bit SHORTCUT = (STABLE_CYCLES == 1);

  typedef enum logic [1:0] {
    LOW,
    RISE_WAIT,
    HIGH,
    FALL_WAIT
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_in;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] cnt_inc;

  logic       level_d;
  logic       rise;
  logic [7:0] events_d;

  // synchronizer chain; the only consumer of the raw input
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in};
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];
  assign cnt_inc = cnt_q + CNT_ONE;

  // state and debounce counter register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOW;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state: a change is accepted after STABLE_CYCLES agreeing samples
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    case (state_q)
      LOW: begin
        if (sync_in) begin
          if (SHORTCUT) begin
            state_d = HIGH;
          end else begin
            state_d = RISE_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
      end
      RISE_WAIT: begin
        if (!sync_in) begin
          state_d = LOW;
        end else if (cnt_inc == CNT_MAX) begin
          state_d = HIGH;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      HIGH: begin
        if (!sync_in) begin
          if (SHORTCUT) begin
            state_d = LOW;
          end else begin
            state_d = FALL_WAIT;
            cnt_d   = CNT_ONE;
          end
        end
      end
      FALL_WAIT: begin
        if (sync_in) begin
          state_d = HIGH;
        end else if (cnt_inc == CNT_MAX) begin
          state_d = LOW;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = LOW;
      end
    endcase
  end

  // output decode: level follows the accepted side, edges become strobes
  always_comb begin
    level_d  = (state_d == HIGH) || (state_d == FALL_WAIT);
    rise     = level_d && !level;
    events_d = events;
    if (rise && (events != 8'hFF)) begin
      events_d = events + 8'd1;
    end
  end

  // registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level  <= 1'b0;
      pulse  <= 1'b0;
      events <= '0;
    end else begin
      level  <= level_d;
      pulse  <= rise;
      events <= events_d;
    end
  end

`ifdef SIGNAL_CONDENSER_FALL_EN
  logic fall;

  assign fall = !level_d && level;

  // falling-edge strobe register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fall_pulse <= 1'b0;
    end else begin
      fall_pulse <= fall;
    end
  end
`else
  assign fall_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_signal_condenser.sv
// tb_signal_condenser: random and directed checks of signal_condenser
// against a sample-window model of the debounce rules.
module tb_signal_condenser;

  localparam int SYNC = 2;
`ifdef SIGNAL_CONDENSER_FALL_EN
  localparam bit FALL_EN = 1'b1;
`else
  localparam bit FALL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in4 = 1'b0;
  logic       in1 = 1'b0;
  logic       lv4, p4, f4;
  logic [7:0] e4;
  logic       lv1, p1, f1;
  logic [7:0] e1;

  int checks = 0;
  int errors = 0;
  int np4 = 0;
  int np1 = 0;
  int base;
  int run = 0;

  always #5 clk = ~clk;

  signal_condenser #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .in(in4),
    .level(lv4), .pulse(p4), .fall_pulse(f4), .events(e4)
  );

  signal_condenser #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .in(in1),
    .level(lv1), .pulse(p1), .fall_pulse(f1), .events(e1)
  );

  // model: the level flips once the last STABLE synchronized samples
  // all disagree with it; synchronized sample = raw input SYNC edges ago
  int          stab [2] = '{4, 1};
  logic [63:0] raw [2];
  logic [63:0] smp [2];
  bit          m_lvl [2];
  bit          m_p [2];
  bit          m_f [2];
  int          m_ev [2];

  task automatic m_clear();
    for (int d = 0; d < 2; d++) begin
      raw[d] = '0;
      smp[d] = '0;
      m_lvl[d] = 1'b0;
      m_p[d] = 1'b0;
      m_f[d] = 1'b0;
      m_ev[d] = 0;
    end
  endtask

  initial begin
    m_clear();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_clear();
      end else begin
        for (int d = 0; d < 2; d++) begin
          logic [63:0] mask;
          raw[d] = {raw[d][62:0], (d == 0) ? in4 : in1};
          smp[d] = {smp[d][62:0], raw[d][SYNC]};
          mask = (64'd1 << stab[d]) - 64'd1;
          m_p[d] = 1'b0;
          m_f[d] = 1'b0;
          if (!m_lvl[d] && ((smp[d] & mask) == mask)) begin
            m_lvl[d] = 1'b1;
            m_p[d] = 1'b1;
            if (m_ev[d] < 255) m_ev[d]++;
          end else if (m_lvl[d] && ((smp[d] & mask) == 64'd0)) begin
            m_lvl[d] = 1'b0;
            m_f[d] = FALL_EN;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clk);
      chk("lvl4", 32'(lv4), 32'(m_lvl[0]));
      chk("pulse4", 32'(p4), 32'(m_p[0]));
      chk("fall4", 32'(f4), 32'(m_f[0]));
      chk("ev4", 32'(e4), 32'(m_ev[0]));
      chk("lvl1", 32'(lv1), 32'(m_lvl[1]));
      chk("pulse1", 32'(p1), 32'(m_p[1]));
      chk("fall1", 32'(f1), 32'(m_f[1]));
      chk("ev1", 32'(e1), 32'(m_ev[1]));
      chk("excl4", 32'(p4 & f4), 32'd0);
      np4 += int'(p4);
      np1 += int'(p1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero4(input string tag);
    chk({tag, "_lvl"}, 32'(lv4), 32'd0);
    chk({tag, "_pulse"}, 32'(p4), 32'd0);
    chk({tag, "_fall"}, 32'(f4), 32'd0);
    chk({tag, "_ev"}, 32'(e4), 32'd0);
  endtask

  task automatic rise_lat4(input string tag);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk({tag, "_lvl"}, 32'(lv4), 32'(k >= 6));
      chk({tag, "_pulse"}, 32'(p4), 32'(k == 6));
    end
  endtask

  initial begin
    // 1: in high through reset, then release
    in4 = 1'b1;
    tick(3);
    #1;
    chk_zero4("rst");
    chk("rst_ev1", 32'(e1), 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    rise_lat4("t1");
    tick(12);
    chk("t1_ev", 32'(e4), 32'd1);

    // 2: clean fall, rise, fall
    @(negedge clk);
    in4 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("t2_lvl", 32'(lv4), 32'(k < 6));
      chk("t2_fall", 32'(f4), 32'(FALL_EN && k == 6));
    end
    in4 = 1'b1;
    rise_lat4("t2r");
    in4 = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      chk("t2b_lvl", 32'(lv4), 32'(k < 6));
      chk("t2b_fall", 32'(f4), 32'(FALL_EN && k == 6));
    end
    chk("t2_ev", 32'(e4), 32'd2);

    // 3: 2-cycle bounce must be rejected
    for (int b = 0; b < 4; b++) begin
      in4 = (b % 2 == 0);
      repeat (2) begin
        @(negedge clk);
        chk("t3_lvl", 32'(lv4), 32'd0);
        chk("t3_pulse", 32'(p4), 32'd0);
      end
    end
    in4 = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("t3_lvl", 32'(lv4), 32'd0);
      chk("t3_pulse", 32'(p4), 32'd0);
    end
    chk("t3_ev", 32'(e4), 32'd2);

    // 4: reset mid rise debounce
    in4 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("t4_pre", 32'(p4), 32'd0);
    end
    #2 reset = 1'b0;
    #1;
    chk_zero4("t4_rst");
    tick(2);
    #2 reset = 1'b1;
    rise_lat4("t4");
    chk("t4_ev", 32'(e4), 32'd1);

    // 5: 260 clean cycles, events saturates
    in4 = 1'b0;
    tick(10);
    base = np4;
    repeat (260) begin
      in4 = 1'b1;
      tick(10);
      in4 = 1'b0;
      tick(10);
    end
    tick(4);
    chk("t5_npulse", 32'(np4 - base), 32'd260);
    chk("t5_ev", 32'(e4), 32'd255);

    // 6: STABLE_CYCLES=1 instance
    in1 = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk("t6_lvl", 32'(lv1), 32'(k >= 3));
      chk("t6_pulse", 32'(p1), 32'(k == 3));
    end
    in1 = 1'b0;
    tick(6);
    chk("t6_low", 32'(lv1), 32'd0);
    base = np1;
    in1 = 1'b1;
    @(negedge clk);
    in1 = 1'b0;
    tick(8);
    chk("t6_glitch", 32'(np1 - base), 32'd1);
    chk("t6_ev", 32'(e1), 32'd2);

    // random phase with occasional async reset
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (run == 0) begin
        in4 = 1'($urandom_range(0, 1));
        run = $urandom_range(1, 9);
      end
      run--;
      in1 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 599) == 0) begin
        #2 reset = 1'b0;
        #1;
        chk_zero4("rnd_rst");
        @(negedge clk);
        #2 reset = 1'b1;
      end
    end
    tick(10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/signal_condenser.md
# signal_condenser

Converts a long, possibly bouncy, asynchronous level (a 3D-simulator sensor line or a board switch) into a debounced level and a single-cycle event pulse. It is the receive-side counterpart of our pulse-to-long-pulse extender: the simulator drives multi-cycle levels into the FPGA, and this block turns them into one-clock strobes for the FSMs and counters downstream. Each instance handles one input line.

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flops on `in`; legal range ≥2.
- `STABLE_CYCLES`, default 50000: number of consecutive synchronized samples at the new value needed to accept a level change; legal range ≥1.
- `clk` input 1: system clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset; clears all state immediately.
- `in` input 1: raw asynchronous level.
- `level` output 1: debounced level.
- `pulse` output 1: high for exactly one cycle when `level` rises.
- `fall_pulse` output 1: high for exactly one cycle when `level` falls. Only active with the macro below.
- `events` output 8: saturating count of `pulse` assertions since reset.

## Operation
- `in` passes through a chain of `SYNC_STAGES` flops. The last flop is `sync_in`. No other logic may read `in`.
- FSM states, with reset state LOW:
  - LOW: `level`=0. When `sync_in`=1, go to RISE_WAIT with count=1. If `STABLE_CYCLES`=1, skip RISE_WAIT and go straight to HIGH.
  - RISE_WAIT: if `sync_in`=0, return to LOW and clear count, with no pulse. Otherwise increment count. On the edge where count reaches `STABLE_CYCLES`, go to HIGH.
  - HIGH: `level`=1. When `sync_in`=0, go to FALL_WAIT with count=1. The `STABLE_CYCLES`=1 shortcut applies here too.
  - FALL_WAIT: mirror of RISE_WAIT. If `sync_in`=1, return to HIGH. When count reaches `STABLE_CYCLES`, go to LOW.
- Outputs are registered:
  - `pulse` is asserted on the same edge that enters HIGH and deasserted on the next edge.
  - `fall_pulse` is asserted on the same edge that enters LOW from FALL_WAIT and deasserted on the next edge.
- Counter:
  - Width is `$clog2(STABLE_CYCLES+1)`.
  - It never exceeds `STABLE_CYCLES`.
  - It is zero in LOW and HIGH.
- `events`:
  - Increments on the edge that asserts `pulse`.
  - Holds at 255 once it reaches 255.
  - No wrap-around.
- A level held for any length produces exactly one `pulse`. `pulse` is never asserted on two consecutive cycles.
- Minimum spacing between consecutive `pulse` assertions is 2×`STABLE_CYCLES` cycles: rise, full fall, full rise.

## Timing
- All outputs are 0 while `reset`=0. This includes `events`=0 and the synchronizer flops, which reset to 0.
- Rise latency: `in` rises and meets setup before edge 1, then stays high. `level` and `pulse` go high after edge `SYNC_STAGES`+`STABLE_CYCLES`.
- Fall latency is the same figure, measured to `level`=0 and `fall_pulse`.
- Glitch rejection: any `sync_in` excursion shorter than `STABLE_CYCLES` samples produces no output change.
- Reset asserted mid-debounce:
  - The pending change is discarded.
  - After release, the FSM is in LOW.
  - If `in` is still high, a fresh full rise latency applies and a new `pulse` results.
- `in` high at reset release is treated as a rising event; there is no suppression at power-up.
- `pulse` and `fall_pulse` are never high in the same cycle.

## Configuration
- `SIGNAL_CONDENSER_FALL_EN`:
  - Defined: the FALL_WAIT→LOW transition drives `fall_pulse` as described above.
  - Undefined: `fall_pulse` is tied to 0. The FSM, `level` and the fall debounce are unchanged.

## Test plan
- Use `SYNC_STAGES`=2 and `STABLE_CYCLES`=4 for all tests.
1. Hold `reset`=0 with `in`=1, then release and hold `in`=1 for 20 cycles.
   - During reset, all outputs are 0.
   - `level` rises after edge 6 following release; `pulse` is high for exactly 1 cycle.
   - `events`=1.
2. Clean rise, then clean fall on `in`.
   - `level`=1 after 6 edges; `level`=0 six edges after the fall.
   - With the macro defined, `fall_pulse` is high for 1 cycle; without it, `fall_pulse` stays 0.
3. Bounce `in` 1,0,1,0 with 2-cycle widths, then leave it low.
   - `level`, `pulse` and `events` remain 0.
4. Start a rise, then assert `reset`=0 asynchronously 3 cycles after `sync_in`=1, mid-RISE_WAIT, for 2 cycles while `in` stays high.
   - No `pulse` appears before reset.
   - All outputs clear immediately on reset.
   - Exactly one `pulse` appears 6 edges after release.
5. Drive 260 clean rise/fall cycles (in high 10 cycles, low 10 cycles).
   - Exactly 260 single-cycle pulses.
   - `events` reaches 255 and holds there.
6. Set `STABLE_CYCLES`=1 and make a single clean rise on `in`.
   - `level` and `pulse` rise after edge 3.
   - A 1-cycle high glitch on `in` is accepted, producing one `pulse`.
